// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch sequencer for the milano IF stage.
// Owns the PC, runs a single-outstanding RAM handshake and feeds ID.
module if_fetch_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] boot_addr_i,
    input  logic              fetch_en_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [DATA_W-1:0] instr_rdata_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_rdata_id_o,
    output logic [ADDR_W-1:0] pc_id_o,
    input  logic              id_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              fetch_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              discard_q;
    logic [7:0]        cnt_q;

    logic granted;
    logic resp;
    logic expired;

    // gnt/rvalid only mean something in the state that expects them
    assign granted = (state == REQ) && instr_gnt_i;
    assign resp    = (state == WAIT) && instr_rvalid_i;
    assign expired = (state == WAIT) && !instr_rvalid_i && (cnt_q == TO_LAST);

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; a redirect steers every state except REQ-without-gnt
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fetch_en_i && !fetch_err_o && !redirect_i) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (instr_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (instr_rvalid_i) begin
                    if (discard_q || redirect_i) begin
                        state_next = REQ;
                    end else begin
                        state_next = HOLD;
                    end
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (id_ready_i || redirect_i) begin
                    state_next = fetch_en_i ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // handshake outputs; the address tracks pc_q only while requesting
    always_comb begin
        instr_req_o   = 1'b0;
        instr_valid_o = 1'b0;
        instr_addr_o  = addr_q;
        unique case (state)
            REQ: begin
                instr_req_o  = 1'b1;
                instr_addr_o = pc_q;
            end
            HOLD: begin
                instr_valid_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC, in-flight tracking, timeout counter and ID-side data registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q             <= boot_addr_i & WORD_MASK;
            inflight_pc_q    <= '0;
            addr_q           <= '0;
            discard_q        <= 1'b0;
            cnt_q            <= '0;
            instr_rdata_id_o <= '0;
            pc_id_o          <= '0;
            fetch_err_o      <= 1'b0;
        end else begin
            if (state == REQ) begin
                addr_q <= pc_q;
            end

            if (redirect_i) begin
                pc_q <= redirect_pc_i & WORD_MASK;
            end else if (granted) begin
                pc_q <= pc_q + STEP;
            end

            if (granted) begin
                inflight_pc_q <= pc_q;
            end

            if (granted) begin
                cnt_q <= '0;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (granted) begin
                discard_q <= redirect_i;
            end else if (state == WAIT) begin
                if (resp || expired) begin
                    discard_q <= 1'b0;
                end else if (redirect_i) begin
                    discard_q <= 1'b1;
                end
            end

            if (resp && !discard_q && !redirect_i) begin
                instr_rdata_id_o <= instr_rdata_i;
                pc_id_o          <= inflight_pc_q;
            end

            if (expired) begin
                fetch_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios plus random traffic for if_fetch_ctrl.
// A transaction-level model predicts request addresses and ID deliveries.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] boot_addr;
    logic        fetch_en;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] rdata_id;
    logic [31:0] pc_id;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        err;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .boot_addr_i     (boot_addr),
        .fetch_en_i      (fetch_en),
        .instr_req_o     (req),
        .instr_addr_o    (addr),
        .instr_gnt_i     (gnt),
        .instr_rvalid_i  (rvalid),
        .instr_rdata_i   (rdata),
        .instr_valid_o   (valid),
        .instr_rdata_id_o(rdata_id),
        .pc_id_o         (pc_id),
        .id_ready_i      (ready),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .fetch_err_o     (err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus knobs
    int          gnt_wait = 0;
    int          rv_lat   = 0;
    bit          redir_req = 0;
    bit          redir_on_req = 0;
    logic [31:0] redir_tgt = 32'h0;
    bit          force_v = 0;
    logic [31:0] force_data = 32'h0;

    // RAM model: one outstanding read, fixed latency after grant
    bit          ram_busy;
    int          ram_cnt;
    logic [31:0] ram_addr;
    int          gcnt;

    // reference model of the fetch stream
    logic [31:0] exp_pc;
    bit          pend_v;
    logic [31:0] pend_pc;
    bit          hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_data;
    bit          prev_stall;
    bit          prev_redir_req;
    logic [31:0] prev_addr;
    bit          last_valid;

    logic [31:0] hs_addr[$];
    int          hs_cyc[$];
    logic [31:0] del_pc[$];
    int          del_cyc[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task do_reset(input logic [31:0] b);
        boot_addr   = b;
        rst         = 1'b1;
        gnt         = 1'b0;
        rvalid      = 1'b0;
        rdata       = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fetch_en    = 1'b1;
        ready       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst            = 1'b0;
        exp_pc         = b & ~32'h3;
        pend_v         = 0;
        hold_v         = 0;
        prev_stall     = 0;
        prev_redir_req = 0;
        last_valid     = 0;
        ram_busy       = 0;
        ram_cnt        = 0;
        gcnt           = 0;
        redir_req      = 0;
        redir_on_req   = 0;
        force_v        = 0;
        hs_addr.delete();
        hs_cyc.delete();
        del_pc.delete();
        del_cyc.delete();
        check("rst_req", req, 0);
        check("rst_valid", valid, 0);
        check("rst_pc_id", pc_id, 0);
        check("rst_rdata_id", rdata_id, 0);
        check("rst_err", err, 0);
    endtask

    // one clock: observe at negedge, choose inputs, advance model, clock
    task tick();
        bit          r;
        bit          g;
        bit          rv;
        logic [31:0] rd;
        cyc++;
        if (prev_stall) begin
            check("req_held", req, 1);
            check("addr_held", addr, prev_addr);
        end
        if (prev_redir_req) begin
            check("req_redir", req, 1);
            check("addr_redir", addr, exp_pc);
        end
        check("valid", valid, hold_v);
        if (hold_v) begin
            check("pc_id", pc_id, hold_pc);
            check("rdata_id", rdata_id, hold_data);
        end
        if (valid && !last_valid) begin
            del_pc.push_back(pc_id);
            del_cyc.push_back(cyc);
        end
        last_valid = valid;

        r = redir_req;
        if (redir_on_req && req) begin
            r = 1;
            redir_on_req = 0;
        end
        redir_req = 0;

        g = 0;
        if (req) begin
            if (gcnt >= gnt_wait) begin
                g = 1;
                gcnt = 0;
            end else begin
                gcnt++;
            end
        end

        rv = 0;
        rd = 32'h0;
        if (ram_busy && ram_cnt == 0) begin
            rv = 1;
            rd = force_v ? force_data : word_of(ram_addr);
            force_v = 0;
            ram_busy = 0;
        end

        if (req && g) begin
            check("req_addr", addr, exp_pc);
            hs_addr.push_back(addr);
            hs_cyc.push_back(cyc);
            ram_busy = 1;
            ram_cnt  = rv_lat;
            ram_addr = addr;
        end else if (ram_busy) begin
            ram_cnt--;
        end

        if (hold_v && (ready || r)) hold_v = 0;
        if (rv) begin
            if (pend_v && !r) begin
                hold_v    = 1;
                hold_pc   = pend_pc;
                hold_data = rd;
            end
            pend_v = 0;
        end
        if (req && g) begin
            pend_v  = !r;
            pend_pc = addr;
        end
        if (r) begin
            exp_pc = redir_tgt & ~32'h3;
            pend_v = 0;
        end else if (req && g) begin
            exp_pc = addr + 32'd4;
        end
        prev_stall     = req && !g && !r;
        prev_redir_req = req && !g && r;
        prev_addr      = addr;

        gnt         = g;
        rvalid      = rv;
        rdata       = rd;
        redirect    = r;
        redirect_pc = redir_tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit got;
        bit saw;
        int n0;
        int nreq;

        // boot: back-to-back fetch at minimum latency
        do_reset(32'h0000_0080);
        repeat (12) tick();
        got = (hs_addr.size() >= 3) && (del_pc.size() >= 3);
        check("boot_count", got, 1);
        if (got) begin
            check("boot_a0", hs_addr[0], 32'h80);
            check("boot_a1", hs_addr[1], 32'h84);
            check("boot_a2", hs_addr[2], 32'h88);
            for (int i = 0; i < 3; i++) begin
                check("boot_pc", del_pc[i], hs_addr[i]);
                check("boot_lat", del_cyc[i] - hs_cyc[i], 2);
            end
            check("boot_rate", hs_cyc[1] - hs_cyc[0], 3);
        end

        // stall: ID holds off for 5 cycles
        ready = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) begin
                got = 1;
                break;
            end
        end
        check("stall_reach", got, 1);
        repeat (5) begin
            check("stall_noreq", req, 0);
            tick();
        end
        check("stall_noreq_end", req, 0);
        ready = 1;
        tick();
        check("stall_req_after", req, 1);

        // redirect while waiting on the RAM
        rv_lat = 2;
        n0 = hs_addr.size();
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_addr.size() > n0) begin
                got = 1;
                break;
            end
        end
        check("rw_grant", got, 1);
        redir_req  = 1;
        redir_tgt  = 32'h0000_0203;
        force_v    = 1;
        force_data = 32'hDEAD_BEEF;
        n0 = hs_addr.size();
        tick();
        got = 0;
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid) saw = 1;
            tick();
            if (hs_addr.size() > n0) begin
                got = 1;
                break;
            end
        end
        check("rw_req", got, 1);
        check("rw_novalid", saw, 0);
        if (got) check("rw_addr", hs_addr[n0], 32'h200);
        rv_lat = 0;

        // redirect in the same cycle as the grant
        do_reset(32'h0000_0100);
        redir_on_req = 1;
        redir_tgt    = 32'h0000_0400;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_addr.size() >= 2 && del_pc.size() >= 1) begin
                got = 1;
                break;
            end
        end
        check("rg_progress", got, 1);
        if (got) begin
            check("rg_a0", hs_addr[0], 32'h100);
            check("rg_a1", hs_addr[1], 32'h400);
            check("rg_del", del_pc[0], 32'h400);
        end

        // delayed grant at the top of the address space
        do_reset(32'hFFFF_FFFC);
        gnt_wait = 3;
        nreq = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (req) nreq++;
            tick();
            if (hs_addr.size() >= 1) begin
                got = 1;
                break;
            end
        end
        check("gd_grant", got, 1);
        check("gd_req_cycles", nreq, 4);
        gnt_wait = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_addr.size() >= 2) begin
                got = 1;
                break;
            end
        end
        check("gd_second", got, 1);
        if (got) begin
            check("gd_a0", hs_addr[0], 32'hFFFF_FFFC);
            check("gd_wrap", hs_addr[1], 32'h0);
        end

        // RAM never answers: timeout, then reset recovers
        do_reset(32'h0000_0040);
        rv_lat = 200;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_addr.size() >= 1) begin
                got = 1;
                break;
            end
        end
        check("to_grant", got, 1);
        repeat (3) begin
            tick();
            check("to_err_early", err, 0);
        end
        tick();
        check("to_err_set", err, 1);
        saw = 0;
        repeat (8) begin
            if (req) saw = 1;
            tick();
        end
        check("to_no_req", saw, 0);
        check("to_err_sticky", err, 1);
        rv_lat = 0;
        do_reset(32'h0000_0040);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_addr.size() >= 1) begin
                got = 1;
                break;
            end
        end
        check("to_restart", got, 1);
        if (got) check("to_restart_addr", hs_addr[0], 32'h40);

        // random traffic against the model
        do_reset($urandom & 32'hFFFF_FFFC);
        for (int i = 0; i < 3000; i++) begin
            fetch_en  = ($urandom % 8) != 0;
            ready     = ($urandom % 3) != 0;
            redir_req = ($urandom % 10) == 0;
            redir_tgt = $urandom;
            gnt_wait  = $urandom_range(0, 2);
            rv_lat    = $urandom_range(0, 2);
            tick();
        end
        check("rand_progress", del_pc.size() > 10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
